// File: rtl/strobe_gen_pkg.sv
// Shared types for the multi-channel delayed strobe generator.
// Holds the per-channel state enum and the mode bit positions.
package strobe_gen_pkg;

   typedef enum logic [1:0] {
      OFF,
      DELAY,
      RUN,
      DONE
   } strobe_state_e;

   localparam int MODE_MARKER_BIT  = 0;
   localparam int MODE_ONESHOT_BIT = 1;

endpackage

// File: rtl/strobe_gen_ch.sv
// One strobe channel: delay after online rise, then strobes spaced by
// interval events (cycles or marker words), free-running or one-shot.
// Ports: clk, rst_n, online, delay_value, interval, mode[1:0],
//        user_marker in; user_strobe, delayed_online, strobe_count out.
module strobe_gen_ch
   import strobe_gen_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             online,
   input  logic [CNT_W-1:0] delay_value,
   input  logic [CNT_W-1:0] interval,
   input  logic [1:0]       mode,
   input  logic             user_marker,
   output logic             user_strobe,
   output logic             delayed_online,
   output logic [CNT_W-1:0] strobe_count
);

   strobe_state_e    state, state_n;
   logic [CNT_W-1:0] dcnt, dcnt_n;
   logic [CNT_W-1:0] icnt, icnt_n;
   logic [CNT_W-1:0] scnt, scnt_n;
   logic             evt;

   // Set only once online has been seen low, so a channel that was
   // online across a reset waits for a fresh rise instead of resuming.
   logic             armed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= OFF;
         dcnt  <= '0;
         icnt  <= '0;
         scnt  <= '0;
         armed <= 1'b0;
      end else begin
         state <= state_n;
         dcnt  <= dcnt_n;
         icnt  <= icnt_n;
         scnt  <= scnt_n;
         armed <= ~online;
      end
   end

   always_comb begin
      state_n = state;
      dcnt_n  = dcnt;
      icnt_n  = icnt;
      scnt_n  = scnt;
      evt     = mode[MODE_MARKER_BIT] ? user_marker : 1'b1;
      if (!online) begin
         state_n = OFF;
         dcnt_n  = '0;
         icnt_n  = '0;
         scnt_n  = '0;
      end else begin
         unique case (state)
            OFF: begin
               if (armed) begin
                  if (delay_value == '0) begin
                     state_n = RUN;
                     icnt_n  = '0;
                  end else begin
                     state_n = DELAY;
                     dcnt_n  = delay_value;
                  end
               end
            end
            DELAY: begin
               // <= 1 also guards against underflow
               if (dcnt <= CNT_W'(1)) begin
                  state_n = RUN;
                  dcnt_n  = '0;
                  icnt_n  = '0;
               end else begin
                  dcnt_n = dcnt - CNT_W'(1);
               end
            end
            RUN: begin
               if (evt) begin
                  if (icnt == '0) begin
                     scnt_n = scnt + CNT_W'(1);
                     if (mode[MODE_ONESHOT_BIT]) begin
                        state_n = DONE;
                     end else begin
                        icnt_n = interval;
                     end
                  end else begin
                     icnt_n = icnt - CNT_W'(1);
                  end
               end
            end
            DONE: begin
               state_n = DONE;
            end
         endcase
      end
   end

   assign user_strobe    = (state == RUN) && (icnt == '0);
   assign delayed_online = (state == RUN) || (state == DONE);
   assign strobe_count   = scnt;

endmodule

// File: rtl/strobe_gen_multi.sv
// NUM_CH independent delayed strobe generators on flat per-channel buses.
// Channel c uses bits [c*CNT_W +: CNT_W], mode [c*2 +: 2], bit c of 1-bit buses.
module strobe_gen_multi #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       online,
   input  logic [NUM_CH*CNT_W-1:0] delay_value,
   input  logic [NUM_CH*CNT_W-1:0] interval,
   input  logic [NUM_CH*2-1:0]     mode,
   input  logic [NUM_CH-1:0]       user_marker,
   output logic [NUM_CH-1:0]       user_strobe,
   output logic [NUM_CH-1:0]       delayed_online,
   output logic [NUM_CH*CNT_W-1:0] strobe_count
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      strobe_gen_ch #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .online        (online[c]),
         .delay_value   (delay_value[c*CNT_W +: CNT_W]),
         .interval      (interval[c*CNT_W +: CNT_W]),
         .mode          (mode[c*2 +: 2]),
         .user_marker   (user_marker[c]),
         .user_strobe   (user_strobe[c]),
         .delayed_online(delayed_online[c]),
         .strobe_count  (strobe_count[c*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_strobe_gen_multi.sv
// Self-checking bench for strobe_gen_multi: marker-mode vector table plus
// directed sequences against a small per-channel timing model.
module tb_strobe_gen_multi;

   localparam int NC = 4;
   localparam int CW = 16;

   logic             clk;
   logic             rst_n;
   logic [NC-1:0]    online;
   logic [NC*CW-1:0] delay_value;
   logic [NC*CW-1:0] interval;
   logic [NC*2-1:0]  mode;
   logic [NC-1:0]    user_marker;
   logic [NC-1:0]    user_strobe;
   logic [NC-1:0]    delayed_online;
   logic [NC*CW-1:0] strobe_count;

   int errors = 0;
   int checks = 0;
   int win_d[NC];
   int win_iv[NC];

   typedef struct {
      logic mk;
      logic st;
      int   cnt;
   } mvec_t;

   mvec_t tbl[13];

   strobe_gen_multi #(.NUM_CH(NC), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .online        (online),
      .delay_value   (delay_value),
      .interval      (interval),
      .mode          (mode),
      .user_marker   (user_marker),
      .user_strobe   (user_strobe),
      .delayed_online(delayed_online),
      .strobe_count  (strobe_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int c,
                      input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s ch%0d: got %0d expected %0d", nm, c, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int c, input int d, input int iv,
                      input logic [1:0] md);
      delay_value[c*CW +: CW] = CW'(d);
      interval[c*CW +: CW]    = CW'(iv);
      mode[c*2 +: 2]          = md;
   endtask

   function automatic int cnt_of(input int c);
      return int'(strobe_count[c*CW +: CW]);
   endfunction

   // Cycle-mode model: online sampled at edge 0; channel enters RUN after
   // edge d and strobes at edges d, d+iv+1, ...; count trails by one edge.
   task automatic run_window(input int n, input logic [NC-1:0] msk);
      int cnt[NC];
      logic es;
      for (int c = 0; c < NC; c++) cnt[c] = 0;
      for (int k = 0; k < n; k++) begin
         step();
         for (int c = 0; c < NC; c++) begin
            if (msk[c]) begin
               es = (k >= win_d[c]) &&
                    (((k - win_d[c]) % (win_iv[c] + 1)) == 0);
               chk("win_don", c, longint'(delayed_online[c]),
                   longint'(k >= win_d[c]));
               chk("win_strobe", c, longint'(user_strobe[c]), longint'(es));
               chk("win_count", c, cnt_of(c), cnt[c]);
               if (es) cnt[c]++;
            end
         end
      end
   endtask

   initial begin
      int n3;
      tbl[0]  = '{1'b0, 1'b1, 0};
      tbl[1]  = '{1'b0, 1'b1, 0};
      tbl[2]  = '{1'b1, 1'b1, 0};
      tbl[3]  = '{1'b0, 1'b0, 1};
      tbl[4]  = '{1'b0, 1'b0, 1};
      tbl[5]  = '{1'b1, 1'b0, 1};
      tbl[6]  = '{1'b1, 1'b0, 1};
      tbl[7]  = '{1'b0, 1'b1, 1};
      tbl[8]  = '{1'b0, 1'b1, 1};
      tbl[9]  = '{1'b1, 1'b1, 1};
      tbl[10] = '{1'b0, 1'b0, 2};
      tbl[11] = '{1'b1, 1'b0, 2};
      tbl[12] = '{1'b0, 1'b0, 2};

      rst_n       = 1'b0;
      online      = '0;
      delay_value = '0;
      interval    = '0;
      mode        = '0;
      user_marker = '0;
      #1;
      chk("rst_strobe", 0, user_strobe, 0);
      chk("rst_don", 0, delayed_online, 0);
      chk("rst_count", 0, strobe_count, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();

      // cycle mode, delay 3, interval 4
      cfg(0, 3, 4, 2'b00);
      online = 4'b0001;
      win_d[0] = 3;
      win_iv[0] = 4;
      run_window(16, 4'b0001);
      chk("cyc_count3", 0, cnt_of(0), 3);
      online = 4'b0000;
      step();
      chk("off_strobe", 0, user_strobe[0], 0);
      chk("off_don", 0, delayed_online[0], 0);
      chk("off_count", 0, cnt_of(0), 0);

      // marker mode, interval 2, delay 0
      cfg(0, 0, 2, 2'b01);
      online = 4'b0001;
      step();
      foreach (tbl[i]) begin
         chk("mk_strobe", 0, user_strobe[0], tbl[i].st);
         chk("mk_count", 0, cnt_of(0), tbl[i].cnt);
         chk("mk_don", 0, delayed_online[0], 1);
         user_marker[0] = tbl[i].mk;
         step();
      end
      user_marker = '0;
      online = 4'b0000;
      step();

      // one-shot, interval 0
      cfg(0, 0, 0, 2'b10);
      online = 4'b0001;
      step();
      chk("os_strobe", 0, user_strobe[0], 1);
      step();
      chk("os_done_strobe", 0, user_strobe[0], 0);
      chk("os_done_don", 0, delayed_online[0], 1);
      chk("os_count", 0, cnt_of(0), 1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("os_hold", 0, user_strobe[0], 0);
      end
      online = 4'b0000;
      step();
      chk("os_off_don", 0, delayed_online[0], 0);
      online = 4'b0001;
      step();
      chk("os_re_strobe", 0, user_strobe[0], 1);
      step();
      chk("os_re_done", 0, user_strobe[0], 0);
      chk("os_re_count", 0, cnt_of(0), 1);
      online = 4'b0000;
      step();

      // drop online mid-DELAY (dcnt = 5), then full delay on re-rise
      cfg(0, 8, 0, 2'b00);
      online = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("dl_don", 0, delayed_online[0], 0);
      end
      online = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("dl_off_don", 0, delayed_online[0], 0);
      end
      online = 4'b0001;
      win_d[0] = 8;
      win_iv[0] = 0;
      run_window(12, 4'b0001);
      online = 4'b0000;
      step();

      // four independent channels
      cfg(0, 0, 0, 2'b00);
      cfg(1, 1, 3, 2'b00);
      cfg(2, 7, 1, 2'b00);
      cfg(3, 0, 65535, 2'b00);
      win_d  = '{0, 1, 7, 0};
      win_iv = '{0, 3, 1, 65535};
      online = 4'b1111;
      run_window(40, 4'b1111);
      n3 = 1;
      for (int k = 40; k < 65536; k++) begin
         step();
         if (user_strobe[3]) n3++;
      end
      chk("ch3_one_strobe", 3, n3, 1);
      step();
      chk("ch3_wrap_strobe", 3, user_strobe[3], 1);
      chk("ch0_high", 0, user_strobe[0], 1);
      online = 4'b0000;
      step();

      // async reset mid-RUN with count 9
      cfg(0, 0, 0, 2'b00);
      online = 4'b0001;
      for (int i = 0; i < 10; i++) step();
      chk("pre_rst_count", 0, cnt_of(0), 9);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_strobe", 0, user_strobe, 0);
      chk("arst_don", 0, delayed_online, 0);
      chk("arst_count", 0, strobe_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("post_rst_strobe", 0, user_strobe[0], 0);
         chk("post_rst_don", 0, delayed_online[0], 0);
      end
      online = 4'b0000;
      step();
      online = 4'b0001;
      step();
      chk("restart_strobe", 0, user_strobe[0], 1);
      chk("restart_count", 0, cnt_of(0), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
